id_exe_pipe_reg: RTL and testbench
==================================

# id_exe_pipe_reg

Parametrised ID→EXE pipeline register with a valid/ready handshake, an optional skid entry, synchronous flush and a saturating stall counter. It sits between the decode stage and the execute stage. It carries the decoded operand and control bundle (dest, reg2, val1, val2, pc, branch-taken, exe command, memory/writeback enables). It lets the execute side back-pressure decode without losing an instruction, and it drops in-flight instructions on a branch flush.

## Interface
- DATA_W, 32, width of val1/val2/reg2/pc
- REG_ADDR_W, 5, destination register index width
- CMD_W, 4, execute command width
- SKID, 1, 1 = two-entry elastic (registered id_ready); 0 = single entry (combinational id_ready)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all held entries and the same-cycle input
- id_valid  in  1  decode presents a bundle
- id_ready  out  1  register accepts a bundle this cycle
- id_dest / id_reg2 / id_val1 / id_val2 / id_pc  in  REG_ADDR_W / DATA_W ×4  payload
- id_br_taken, id_mem_r_en, id_mem_w_en, id_wb_en  in  1 each  control payload
- id_exe_cmd  in  CMD_W  control payload
- exe_valid  out  1  head entry valid
- exe_ready  in  1  execute consumes the head entry this cycle
- exe_dest / exe_reg2 / exe_val1 / exe_val2 / exe_pc / exe_exe_cmd  out  head payload
- exe_br_taken, exe_mem_r_en, exe_mem_w_en, exe_wb_en  out  1 each  head control, gated by exe_valid
- stall_cnt  out  CNT_W  saturating count of cycles with exe_valid=1 and exe_ready=0

## Operation
- Transfers: in_fire = id_valid & id_ready; out_fire = exe_valid & exe_ready.
- State (SKID=1): EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY: in_fire → ONE, main ← input.
  - ONE: in_fire & out_fire → ONE, main ← input. in_fire & !out_fire → TWO, skid ← input. out_fire only → EMPTY.
  - TWO: out_fire → ONE, main ← skid. Otherwise hold. No input is accepted in TWO.
  - id_ready = (state != TWO), decoded from the state register only.
- SKID=0: states EMPTY/ONE only. id_ready = !exe_valid | exe_ready (combinational). A simultaneous in_fire and out_fire reloads main.
- flush has priority over every transfer: next state EMPTY, same-cycle input dropped, main/skid control bits (br_taken, mem_r_en, mem_w_en, wb_en) cleared. Data fields may retain their values. stall_cnt is unaffected.
- Control outputs exe_br_taken/mem_r_en/mem_w_en/wb_en are ANDed with exe_valid. A bubble never writes memory or the register file.
- Order is preserved: the skid entry is always younger than main.
- stall_cnt increments on each stall cycle, saturates at 2^CNT_W−1, and never wraps.

## Timing
- Reset (rst=0, asynchronous): state EMPTY, all payload registers 0, exe_valid=0, all exe_* outputs 0, stall_cnt=0. id_ready=1 in both modes.
- Reset asserted mid-transfer: all entries are lost immediately, with no partial update.
- Latency: a bundle accepted at edge N appears on exe_* after edge N (same cycle N+1) when the register was EMPTY or main was consumed at edge N.
- Throughput: one bundle per cycle while exe_ready=1.
- SKID=1: id_ready falls one cycle after the first stall cycle in which input was also accepted. At most one extra bundle is absorbed.
- flush at edge N: exe_valid=0 after edge N. id_ready=1 after edge N.

## Test plan
- Reset then stream: assert rst=0, release, drive 8 bundles with pc=0x00,0x04…0x1C and exe_ready=1 → exe_pc follows one cycle later, exe_valid continuous, stall_cnt=0.
- Back-pressure (SKID=1): exe_ready=0 while pc=0x40,0x44 are offered → both accepted, id_ready=0 on the next cycle. Release exe_ready → 0x40 then 0x44 out in order, stall_cnt equals the held cycles.
- Flush in TWO: entries pc=0x80/0x84 held, id_valid with pc=0x88 and flush=1 → exe_valid=0, exe_wb_en=0, exe_mem_w_en=0 next cycle, 0x88 never appears.
- SKID=0 back-pressure: main holds pc=0x10 with exe_ready=0 → id_ready=0 combinationally. Raising exe_ready in the same cycle → id_ready=1, and 0x14 loads that edge.
- Stall counter saturation: CNT_W=4, hold a valid entry with exe_ready=0 for 20 cycles → stall_cnt stops at 15.
- Async reset mid-stream: pull rst low between edges with two entries held → exe_valid=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module id_exe_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [DATA_W-1:0]     id_reg2,
  input  logic [DATA_W-1:0]     id_val1,
  input  logic [DATA_W-1:0]     id_val2,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic                  id_br_taken,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_wb_en,
  input  logic [CMD_W-1:0]      id_exe_cmd,
  output logic                  exe_valid,
  input  logic                  exe_ready,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic [DATA_W-1:0]     exe_reg2,
  output logic [DATA_W-1:0]     exe_val1,
  output logic [DATA_W-1:0]     exe_val2,
  output logic [DATA_W-1:0]     exe_pc,
  output logic [CMD_W-1:0]      exe_exe_cmd,
  output logic                  exe_br_taken,
  output logic                  exe_mem_r_en,
  output logic                  exe_mem_w_en,
  output logic                  exe_wb_en,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     reg2;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [DATA_W-1:0]     pc;
    logic                  br_taken;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;
    logic [CMD_W-1:0]      exe_cmd;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  bundle_t         main_q, main_d;
  bundle_t         skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  bundle_t         in_bundle;
  logic            in_fire, out_fire;

  // Drops the control bits so a flushed entry can never commit side effects.
  function automatic bundle_t clr_ctrl(input bundle_t b);
    bundle_t r;
    r          = b;
    r.br_taken = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    r.wb_en    = 1'b0;
    return r;
  endfunction

  // Handshake decode and input bundle packing.
  always_comb begin
    in_bundle = '{dest: id_dest, reg2: id_reg2, val1: id_val1, val2: id_val2, pc: id_pc,
                  br_taken: id_br_taken, mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en,
                  wb_en: id_wb_en, exe_cmd: id_exe_cmd};
    exe_valid = (state_q != StEmpty);
    if (SKID != 0) id_ready = (state_q != StTwo);
    else           id_ready = !exe_valid || exe_ready;
    in_fire  = id_valid && id_ready;
    out_fire = exe_valid && exe_ready;
  end

  // Next-state for occupancy, entries and stall counter; flush overrides transfers.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;
    if (exe_valid && !exe_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush) begin
      state_d = StEmpty;
      main_d  = clr_ctrl(main_q);
      skid_d  = clr_ctrl(skid_q);
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_bundle;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_bundle;
          end else if (in_fire && (SKID != 0)) begin
            // Younger bundle parks in skid while main waits for execute.
            state_d = StTwo;
            skid_d  = in_bundle;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Head entry outputs; control bits gated so a bubble has no side effects.
  always_comb begin
    exe_dest     = main_q.dest;
    exe_reg2     = main_q.reg2;
    exe_val1     = main_q.val1;
    exe_val2     = main_q.val2;
    exe_pc       = main_q.pc;
    exe_exe_cmd  = main_q.exe_cmd;
    exe_br_taken = main_q.br_taken && exe_valid;
    exe_mem_r_en = main_q.mem_r_en && exe_valid;
    exe_mem_w_en = main_q.mem_w_en && exe_valid;
    exe_wb_en    = main_q.wb_en && exe_valid;
    stall_cnt    = stall_cnt_q;
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: instance a is SKID=1 with a 4-bit stall counter,
// instance b is SKID=0 with a 16-bit counter. Both share the same input stimulus.
module tb_id_exe_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_dest;
  logic [31:0] id_reg2, id_val1, id_val2, id_pc;
  logic        id_br_taken, id_mem_r_en, id_mem_w_en, id_wb_en;
  logic [3:0]  id_exe_cmd;
  logic        exe_ready;

  logic        id_ready_a, exe_valid_a;
  logic [4:0]  exe_dest_a;
  logic [31:0] exe_reg2_a, exe_val1_a, exe_val2_a, exe_pc_a;
  logic [3:0]  exe_exe_cmd_a;
  logic        exe_br_taken_a, exe_mem_r_en_a, exe_mem_w_en_a, exe_wb_en_a;
  logic [3:0]  stall_cnt_a;

  logic        id_ready_b, exe_valid_b;
  logic [4:0]  exe_dest_b;
  logic [31:0] exe_reg2_b, exe_val1_b, exe_val2_b, exe_pc_b;
  logic [3:0]  exe_exe_cmd_b;
  logic        exe_br_taken_b, exe_mem_r_en_b, exe_mem_w_en_b, exe_wb_en_b;
  logic [15:0] stall_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  id_exe_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CMD_W(4), .SKID(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready_a),
    .id_dest(id_dest), .id_reg2(id_reg2), .id_val1(id_val1), .id_val2(id_val2),
    .id_pc(id_pc), .id_br_taken(id_br_taken), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en), .id_exe_cmd(id_exe_cmd),
    .exe_valid(exe_valid_a), .exe_ready(exe_ready), .exe_dest(exe_dest_a),
    .exe_reg2(exe_reg2_a), .exe_val1(exe_val1_a), .exe_val2(exe_val2_a), .exe_pc(exe_pc_a),
    .exe_exe_cmd(exe_exe_cmd_a), .exe_br_taken(exe_br_taken_a),
    .exe_mem_r_en(exe_mem_r_en_a), .exe_mem_w_en(exe_mem_w_en_a), .exe_wb_en(exe_wb_en_a),
    .stall_cnt(stall_cnt_a)
  );

  id_exe_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CMD_W(4), .SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready_b),
    .id_dest(id_dest), .id_reg2(id_reg2), .id_val1(id_val1), .id_val2(id_val2),
    .id_pc(id_pc), .id_br_taken(id_br_taken), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en), .id_exe_cmd(id_exe_cmd),
    .exe_valid(exe_valid_b), .exe_ready(exe_ready), .exe_dest(exe_dest_b),
    .exe_reg2(exe_reg2_b), .exe_val1(exe_val1_b), .exe_val2(exe_val2_b), .exe_pc(exe_pc_b),
    .exe_exe_cmd(exe_exe_cmd_b), .exe_br_taken(exe_br_taken_b),
    .exe_mem_r_en(exe_mem_r_en_b), .exe_mem_w_en(exe_mem_w_en_b), .exe_wb_en(exe_wb_en_b),
    .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload fields are derived from pc so any field can be predicted.
  task automatic offer(input logic v, input logic [31:0] pc, input logic wb, input logic mw);
    id_valid    = v;
    id_pc       = pc;
    id_dest     = pc[6:2];
    id_reg2     = pc + 32'h2;
    id_val1     = pc ^ 32'hA5A5_0000;
    id_val2     = ~pc;
    id_exe_cmd  = pc[5:2];
    id_br_taken = 1'b0;
    id_mem_r_en = 1'b0;
    id_mem_w_en = mw;
    id_wb_en    = wb;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    exe_ready = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check("rst_valid", {31'b0, exe_valid_a}, 32'd0);
    check("rst_pc", exe_pc_a, 32'h0);
    check("rst_wb", {31'b0, exe_wb_en_a}, 32'd0);
    check("rst_stall", {28'b0, stall_cnt_a}, 32'd0);
    check("rst_ready_a", {31'b0, id_ready_a}, 32'd1);
    check("rst_ready_b", {31'b0, id_ready_b}, 32'd1);
    rst = 1'b1;

    // Stream 8 bundles with execute always ready.
    exe_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'(i * 4), 1'b1, 1'b0);
      tick();
      check("stream_valid", {31'b0, exe_valid_a}, 32'd1);
      check("stream_pc", exe_pc_a, 32'(i * 4));
      check("stream_pc_b", exe_pc_b, 32'(i * 4));
    end
    check("stream_val1", exe_val1_a, 32'h1C ^ 32'hA5A5_0000);
    check("stream_dest", {27'b0, exe_dest_a}, 32'd7);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("stream_drain", {31'b0, exe_valid_a}, 32'd0);
    check("stream_stall", {28'b0, stall_cnt_a}, 32'd0);

    // Back-pressure into the skid entry.
    do_reset();
    exe_ready = 1'b0;
    offer(1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    check("bp_pc0", exe_pc_a, 32'h40);
    check("bp_ready0", {31'b0, id_ready_a}, 32'd1);
    offer(1'b1, 32'h44, 1'b1, 1'b0);
    tick();
    check("bp_ready1", {31'b0, id_ready_a}, 32'd0);
    check("bp_head", exe_pc_a, 32'h40);
    check("bp_stall1", {28'b0, stall_cnt_a}, 32'd1);
    offer(1'b1, 32'h48, 1'b1, 1'b0);
    tick();
    check("bp_hold", exe_pc_a, 32'h40);
    check("bp_stall2", {28'b0, stall_cnt_a}, 32'd2);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    exe_ready = 1'b1;
    tick();
    check("bp_second", exe_pc_a, 32'h44);
    check("bp_second_v", {31'b0, exe_valid_a}, 32'd1);
    check("bp_ready2", {31'b0, id_ready_a}, 32'd1);
    tick();
    check("bp_empty", {31'b0, exe_valid_a}, 32'd0);
    check("bp_stall_end", {28'b0, stall_cnt_a}, 32'd2);

    // Flush while two entries are held.
    do_reset();
    exe_ready = 1'b0;
    offer(1'b1, 32'h80, 1'b1, 1'b1);
    tick();
    offer(1'b1, 32'h84, 1'b1, 1'b1);
    tick();
    check("fl_wb_pre", {31'b0, exe_wb_en_a}, 32'd1);
    check("fl_mw_pre", {31'b0, exe_mem_w_en_a}, 32'd1);
    offer(1'b1, 32'h88, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    check("fl_valid", {31'b0, exe_valid_a}, 32'd0);
    check("fl_wb", {31'b0, exe_wb_en_a}, 32'd0);
    check("fl_mw", {31'b0, exe_mem_w_en_a}, 32'd0);
    check("fl_ready", {31'b0, id_ready_a}, 32'd1);
    check("fl_stall", {28'b0, stall_cnt_a}, 32'd2);
    exe_ready = 1'b1;
    tick();
    tick();
    check("fl_no88", {31'b0, exe_valid_a}, 32'd0);

    // SKID=0: combinational id_ready.
    do_reset();
    exe_ready = 1'b0;
    offer(1'b1, 32'h10, 1'b1, 1'b0);
    tick();
    check("s0_pc0", exe_pc_b, 32'h10);
    offer(1'b1, 32'h14, 1'b1, 1'b0);
    #1;
    check("s0_ready_lo", {31'b0, id_ready_b}, 32'd0);
    tick();
    check("s0_hold", exe_pc_b, 32'h10);
    exe_ready = 1'b1;
    #1;
    check("s0_ready_hi", {31'b0, id_ready_b}, 32'd1);
    tick();
    check("s0_pc1", exe_pc_b, 32'h14);
    check("s0_valid", {31'b0, exe_valid_b}, 32'd1);

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    exe_ready = 1'b0;
    offer(1'b1, 32'hC0, 1'b0, 1'b0);
    tick();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) check("sat_mid", {28'b0, stall_cnt_a}, 32'd10);
    end
    check("sat_a", {28'b0, stall_cnt_a}, 32'd15);
    check("sat_b", {16'b0, stall_cnt_b}, 32'd20);

    // Asynchronous reset with two entries held.
    do_reset();
    exe_ready = 1'b0;
    offer(1'b1, 32'h100, 1'b1, 1'b1);
    tick();
    offer(1'b1, 32'h104, 1'b1, 1'b1);
    tick();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    check("ar_pre_ready", {31'b0, id_ready_a}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", {31'b0, exe_valid_a}, 32'd0);
    check("ar_pc", exe_pc_a, 32'h0);
    check("ar_wb", {31'b0, exe_wb_en_a}, 32'd0);
    check("ar_mw", {31'b0, exe_mem_w_en_a}, 32'd0);
    check("ar_stall", {28'b0, stall_cnt_a}, 32'd0);
    check("ar_ready", {31'b0, id_ready_a}, 32'd1);
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
